adc_spi_master: RTL
===================

Name: adc_spi_master

Overview:
- Synthesizable SPI master that drives the stereo ADC peripheral through SCK, SDI and CS_, and collects its SDO stream.
- Issues channel-select commands and handles the ADC's one-frame command pipeline.
- Converts the offset-binary ADC words back to signed 1.15.
- Presents one left/right sample pair per request to the downstream filter/equalizer datapath.

Parameters:
- CLK_DIV, 4, CLK cycles per SCK half-period (legal range 1..255).
- CMD_LOW, 14'h0000, constant ADC configuration bits placed in command bits [13:0].

Ports:
- CLK  input  1  system clock; all logic is on posedge.
- RESET_  input  1  synchronous reset, active low.
- EN  input  1  enables the ADC session. While high, CS_ is held low across all frames.
- SAMPLE_REQ  input  1  single-cycle request for one L/R sample pair.
- SCK  output  1  SPI clock; idles low.
- CS_  output  1  ADC chip select, active low.
- SDI  output  1  command bit to the ADC, MSB first.
- SDO  input  1  data bit from the ADC, MSB first.
- BUSY  output  1  high whenever the block is not in READY.
- L_OUT  output  16  left sample, signed 1.15.
- R_OUT  output  16  right sample, signed 1.15.
- OUT_VALID  output  1  one-cycle strobe; L_OUT and R_OUT are valid and held until the next strobe.
- OVERRUN  output  1  one-cycle pulse when SAMPLE_REQ is dropped.

Behaviour:
- Reset: RESET_ is sampled low at posedge CLK. It overrides everything, including mid-frame activity. After reset:
  - state=IDLE
  - SCK=0, CS_=1, SDI=0
  - BUSY=1
  - L_OUT=0, R_OUT=0
  - OUT_VALID=0, OVERRUN=0
  - all counters and shift registers cleared
- Command word: {1'b1, chan, CMD_LOW}. chan=0 selects L (bits[15:14]=2'b10); chan=1 selects R (2'b11).
- ADC pipeline rule: data returned in frame n answers the command sent in frame n-1.
- Frame definition: 16 bit periods, MSB first. Each bit period is:
  - CLK_DIV cycles with SCK=0. SDI is updated on the first cycle of this phase.
  - then CLK_DIV cycles with SCK=1.
  - SDO is captured into the rx shift register on the CLK edge that drives SCK from 1 to 0, before the ADC changes SDO.
  - Frame length is 32*CLK_DIV cycles. Consecutive frames within a request have no gap.
- States:
  - IDLE: CS_=1. When EN=1, go to SETUP and drive CS_=0.
  - SETUP: CS_=0, SCK=0 for CLK_DIV cycles, then go to PRIME.
  - PRIME: one frame sending the L command. Received data is discarded. Then go to READY.
  - READY: BUSY=0.
    - If EN=0: CS_=1, go to IDLE.
    - Else if SAMPLE_REQ=1: go to FRAME_A.
    - EN=0 takes priority over a simultaneous SAMPLE_REQ; that request is dropped silently (no OVERRUN).
  - FRAME_A: send the R command; receive the L word.
  - FRAME_B: send the L command; receive the R word.
  - After FRAME_B completes:
    - L_OUT={~rxA[15], rxA[14:0]}
    - R_OUT={~rxB[15], rxB[14:0]}
    - OUT_VALID=1 for that one cycle; return to READY.
- Latency: SAMPLE_REQ accepted at cycle t gives OUT_VALID at cycle t+1+64*CLK_DIV (t+257 at default).
- Drop rule: SAMPLE_REQ seen while state is not READY (IDLE, SETUP, PRIME, FRAME_A, FRAME_B) is dropped and OVERRUN pulses the next cycle.
- EN deasserted mid-frame or mid-PRIME: the current request or prime completes, then CS_ rises from READY. Because every frame ends with SCK low, CS_ never toggles while SCK=1.
- Re-session: EN toggles back high, giving a new CS_ fall, SETUP and PRIME. There is no OUT_VALID until the next request completes.
- Reset mid-frame: SCK=0 and CS_=1 on the next cycle. The partial frame is abandoned; L_OUT and R_OUT are cleared.

Test Plan:
- Reset/idle: hold RESET_=0 for 3 cycles with EN=0 -> SCK=0, CS_=1, OUT_VALID=0, L_OUT=R_OUT=0, BUSY=1. After release with EN=0, these hold for 100 cycles.
- Prime: EN=1 at default CLK_DIV -> CS_ falls; first SCK rise after 4+4 cycles; 16 SCK pulses; SDI bits = 16'h8000; BUSY drops after the frame.
- Sample pair: ADC model with left word 16'h1234 and right word 16'hF000 (it sends 16'h9234 and 16'h7000); pulse SAMPLE_REQ ->
  - SDI = 16'hC000 then 16'h8000
  - OUT_VALID exactly 257 cycles after the request
  - L_OUT=16'h1234, R_OUT=16'hF000
- Overrun: second SAMPLE_REQ 50 cycles after the first -> OVERRUN pulses once; only one OUT_VALID; ADC sees exactly 32 SCK pulses.
- EN drop mid-FRAME_A -> both frames complete, OUT_VALID fires, then CS_=1 with SCK low. Re-raising EN produces a new prime frame.
- Reset mid-FRAME_B with CLK_DIV=1 -> SCK=0 and CS_=1 next cycle, outputs cleared. A new EN session returns correct data for the next 10 pairs.

Source files
------------

// File: rtl/adc_spi_master.sv
// SPI master for the stereo ADC: primes the one-frame command pipeline, fetches one
// left/right pair per request and converts the offset-binary words to signed 1.15.
module adc_spi_master #(
    parameter int          CLK_DIV = 4,
    parameter logic [13:0] CMD_LOW = 14'h0000
) (
    input  logic        CLK,
    input  logic        RESET_,
    input  logic        EN,
    input  logic        SAMPLE_REQ,
    output logic        SCK,
    output logic        CS_,
    output logic        SDI,
    input  logic        SDO,
    output logic        BUSY,
    output logic [15:0] L_OUT,
    output logic [15:0] R_OUT,
    output logic        OUT_VALID,
    output logic        OVERRUN
);
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PRIME,
        READY,
        FRAME_A,
        FRAME_B
    } state_t;

    localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [15:0] CMD_L    = {2'b10, CMD_LOW};
    localparam logic [15:0] CMD_R    = {2'b11, CMD_LOW};

    state_t      state;
    state_t      state_next;
    logic [7:0]  div_cnt;
    logic [3:0]  bit_cnt;
    logic [15:0] tx_shift;
    logic [15:0] rx_shift;
    logic [15:0] rx_a;
    logic [15:0] rx_next;
    logic [15:0] cmd_next;
    logic        in_frame;
    logic        half_end;
    logic        bit_end;
    logic        frame_done;
    logic        frame_start;

    always_comb begin
        in_frame   = (state == PRIME) || (state == FRAME_A) || (state == FRAME_B);
        half_end   = (div_cnt == DIV_LAST);
        bit_end    = in_frame && half_end && SCK;
        frame_done = bit_end && (bit_cnt == 4'd15);
        rx_next    = {rx_shift[14:0], SDO};
    end

    always_ff @(posedge CLK) begin
        if (!RESET_) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (EN) state_next = SETUP;
            SETUP:   if (half_end) state_next = PRIME;
            PRIME:   if (frame_done) state_next = READY;
            READY: begin
                if (!EN) begin
                    state_next = IDLE;
                end else if (SAMPLE_REQ) begin
                    state_next = FRAME_A;
                end
            end
            FRAME_A: if (frame_done) state_next = FRAME_B;
            FRAME_B: if (frame_done) state_next = READY;
            default: state_next = IDLE;
        endcase
        frame_start = (state_next != state) &&
                      ((state_next == PRIME) || (state_next == FRAME_A) || (state_next == FRAME_B));
        // FRAME_A asks for R while the L word arrives; every other frame asks for L.
        cmd_next = (state_next == FRAME_A) ? CMD_R : CMD_L;
    end

    assign BUSY = (state != READY);

    always_ff @(posedge CLK) begin
        if (!RESET_) begin
            SCK       <= 1'b0;
            CS_       <= 1'b1;
            SDI       <= 1'b0;
            div_cnt   <= 8'd0;
            bit_cnt   <= 4'd0;
            tx_shift  <= 16'd0;
            rx_shift  <= 16'd0;
            rx_a      <= 16'd0;
            L_OUT     <= 16'd0;
            R_OUT     <= 16'd0;
            OUT_VALID <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            CS_       <= (state_next == IDLE);
            OUT_VALID <= 1'b0;
            OVERRUN   <= SAMPLE_REQ && (state != READY);

            if (bit_end) begin
                rx_shift <= rx_next;
            end
            if (frame_done && (state == FRAME_A)) begin
                rx_a <= rx_next;
            end
            if (frame_done && (state == FRAME_B)) begin
                L_OUT     <= {~rx_a[15], rx_a[14:0]};
                R_OUT     <= {~rx_next[15], rx_next[14:0]};
                OUT_VALID <= 1'b1;
            end

            // SDI moves only as SCK falls, so the ADC always samples a settled bit.
            if (frame_start) begin
                SCK      <= 1'b0;
                div_cnt  <= 8'd0;
                bit_cnt  <= 4'd0;
                SDI      <= cmd_next[15];
                tx_shift <= {cmd_next[14:0], 1'b0};
            end else if (state == SETUP) begin
                div_cnt <= half_end ? 8'd0 : div_cnt + 8'd1;
            end else if (in_frame) begin
                if (!half_end) begin
                    div_cnt <= div_cnt + 8'd1;
                end else begin
                    div_cnt <= 8'd0;
                    SCK     <= ~SCK;
                    if (SCK) begin
                        bit_cnt  <= bit_cnt + 4'd1;
                        SDI      <= tx_shift[15];
                        tx_shift <= {tx_shift[14:0], 1'b0};
                    end
                end
            end else begin
                div_cnt <= 8'd0;
                SDI     <= 1'b0;
            end
        end
    end
endmodule
